adder_share_arb: RTL and testbench
==================================

# adder_share_arb

Round-robin arbiter and sequencer that shares one combinational WIDTH-bit adder (sum and carry out) between NUM_REQ requesters in the FIR datapath. It selects one requester and drives the shared adder with that requester's operands. It captures the sum and carry, then returns them with the requester's index. Only one add is in flight at a time.

## Interface
- NUM_REQ, default 4: number of requesters, 2..8.
- WIDTH, default 4: operand width of the shared adder.
- IDW, default 2: index width, equal to clog2(NUM_REQ).

Ports:
- clk  in  1: single clock, rising edge.
- rst  in  1: asynchronous, active-high reset.
- req  in  NUM_REQ: request per requester. Held high until that requester's gnt bit is seen.
- a_in  in  NUM_REQ*WIDTH: flattened A operands; requester i uses bits [i*WIDTH +: WIDTH].
- b_in  in  NUM_REQ*WIDTH: flattened B operands, same packing as a_in.
- gnt  out  NUM_REQ: one-hot grant, one-cycle pulse.
- add_a  out  WIDTH: A operand to the shared adder.
- add_b  out  WIDTH: B operand to the shared adder.
- add_sum  in  WIDTH: sum from the shared adder.
- add_carry  in  1: carry from the shared adder.
- rsp_valid  out  1: one-cycle response strobe.
- rsp_id  out  IDW: index of the served requester.
- rsp_sum  out  WIDTH: registered sum.
- rsp_carry  out  1: registered carry.
- busy  out  1: high in OP and DONE states.

## Operation
- FSM states: IDLE, OP, DONE. Reset state is IDLE.
- Round-robin pointer ptr is IDW bits wide, reset value 0.
- Arbitration:
  - The winner is the first set req bit scanning ptr, ptr+1, … with wrap modulo NUM_REQ.
  - Arbitration runs on the clock edge while in IDLE or DONE.
- IDLE:
  - If any req is set: latch the winner index into cur_id and its operands into op_a/op_b, then go to OP.
  - Otherwise stay in IDLE.
- OP:
  - add_a = op_a and add_b = op_b, driven from registers.
  - gnt[cur_id] = 1.
  - At the end of the cycle, capture add_sum into rsp_sum and add_carry into rsp_carry, and set ptr = (cur_id + 1) mod NUM_REQ.
  - Next state is DONE.
- DONE:
  - rsp_valid = 1 and rsp_id = cur_id.
  - Arbitrate with the updated ptr. If any req is set, latch the new winner and go to OP; otherwise go to IDLE.
- Outside OP, add_a and add_b are 0.
- Requester contract:
  - A requester seeing gnt drops req at the next edge, so its req is low in DONE.
  - A requester may re-raise req later; the rotated pointer guarantees fairness.
- rsp_sum, rsp_carry and rsp_id hold their values until the next capture.

## Timing
- Reset values:
  - gnt = 0, rsp_valid = 0, rsp_id = 0, rsp_sum = 0, rsp_carry = 0.
  - add_a = 0, add_b = 0, busy = 0.
  - Internal: ptr = 0, state IDLE.
- Latency:
  - req sampled at edge k gives gnt high in cycle k..k+1 (OP).
  - rsp_valid is high in the following cycle (DONE).
- Throughput under continuous requests: one add per 2 cycles (OP, DONE, OP, …).
- Simultaneous requests: the lowest index at or after ptr wins; the others wait with req held.
- A req dropped before grant is legal; it is simply not served.
- Operand changes after grant are ignored, because operands are latched.
- Reset asserted mid-operation:
  - All outputs clear immediately (asynchronous); no rsp_valid is produced for the aborted operation.
  - After rst deasserts, arbitration restarts from ptr = 0.

## Configuration
- Macro ADDER_SHARE_ARB_SAT_EN.
- Defined: saturating mode.
  - When add_carry = 1 in OP, rsp_sum is captured as all ones (4'hF for WIDTH = 4).
  - rsp_carry still reports 1.
- Undefined: rsp_sum is the raw add_sum, wrapping modulo 2^WIDTH.

## Test plan
- Single request: req = 4'b0001 with a = 4'h3, b = 4'hA.
  - Expect gnt = 4'b0001 one cycle after the request is sampled.
  - Next cycle: rsp_valid = 1, rsp_id = 0, rsp_sum = 4'hD, rsp_carry = 0.
- All four requesting at once from reset, each dropping req after its grant.
  - Grants occur in order 0, 1, 2, 3 on alternating cycles, 8 cycles total.
  - No grant is duplicated.
- Fairness: requesters 1 and 3 hold req continuously, re-raising immediately after each grant.
  - Grants alternate 1, 3, 1, 3.
  - busy stays high throughout.
- Overflow: a = 4'h5, b = 4'hB.
  - Without the macro: rsp_sum = 4'h0, rsp_carry = 1.
  - With ADDER_SHARE_ARB_SAT_EN: rsp_sum = 4'hF, rsp_carry = 1.
- Operand change after grant: a_in changes to 4'hF during DONE.
  - rsp_sum still reflects the latched operands, e.g. 7 + 4 = 4'hB.
- Reset during OP:
  - gnt, busy and rsp_valid are 0 immediately.
  - After release with req = 4'b1000, the grant goes to requester 3 and ptr is shown reset by the following order.

Source files
------------

// File: rtl/adder_share_arb.sv
// adder_share_arb: round-robin arbiter time-sharing one WIDTH-bit adder among NUM_REQ requesters.
// Define ADDER_SHARE_ARB_SAT_EN to capture an all-ones sum whenever the adder carries out.
module adder_share_arb #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int IDW     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] a_in,
  input  logic [NUM_REQ*WIDTH-1:0] b_in,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         add_a,
  output logic [WIDTH-1:0]         add_b,
  input  logic [WIDTH-1:0]         add_sum,
  input  logic                     add_carry,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     rsp_carry,
  output logic                     busy
);
  typedef enum logic [1:0] {IDLE, OP, DONE} state_t;
  state_t state, state_n;
  logic [IDW-1:0] ptr, cur_id, win, k;
  logic any;
  logic [WIDTH-1:0] op_a, op_b, cap_sum;
`ifdef ADDER_SHARE_ARB_SAT_EN
  assign cap_sum = add_carry ? '1 : add_sum;
`else
  assign cap_sum = add_sum;
`endif
  // Scan from the farthest offset down so the requester nearest ptr is written last and wins.
  always_comb begin
    any = 1'b0;
    win = '0;
    k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = IDW'((int'(ptr) + i) % NUM_REQ);
      if (req[k]) begin
        any = 1'b1;
        win = k;
      end
    end
  end
  always_comb begin
    state_n = state == OP ? DONE : (any ? OP : IDLE);
    gnt = state == OP ? NUM_REQ'(1) << cur_id : '0;
    add_a = state == OP ? op_a : '0;
    add_b = state == OP ? op_b : '0;
    rsp_valid = state == DONE;
    busy = state != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      cur_id <= '0;
      op_a <= '0;
      op_b <= '0;
      rsp_id <= '0;
      rsp_sum <= '0;
      rsp_carry <= 1'b0;
    end else begin
      state <= state_n;
      if (state == OP) begin
        rsp_sum <= cap_sum;
        rsp_carry <= add_carry;
        rsp_id <= cur_id;
        ptr <= cur_id == IDW'(NUM_REQ - 1) ? '0 : cur_id + IDW'(1);
      end else if (any) begin
        cur_id <= win;
        op_a <= a_in[int'(win)*WIDTH +: WIDTH];
        op_b <= b_in[int'(win)*WIDTH +: WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_adder_share_arb.sv
// tb_adder_share_arb: randomized and directed check of adder_share_arb against a transaction-level model.
module tb_adder_share_arb;
  localparam int N = 4, W = 4, IW = 2;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] a_in = '0, b_in = '0;
  logic [N-1:0] gnt;
  logic [W-1:0] add_a, add_b, add_sum, rsp_sum;
  logic add_carry, rsp_valid, rsp_carry, busy;
  logic [IW-1:0] rsp_id;
  adder_share_arb #(.NUM_REQ(N), .WIDTH(W), .IDW(IW)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .gnt(gnt),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .add_carry(add_carry),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry), .busy(busy)
  );
  assign {add_carry, add_sum} = {1'b0, add_a} + {1'b0, add_b};
  always #5 clk = ~clk;
  int ncmp, nbad;
  int cur_g, nxt_g, cur_ptr, nxt_ptr, cur_rid, nxt_rid;
  bit cur_v, nxt_v, cur_rc, nxt_rc, rnd;
  logic [W-1:0] cur_rs, nxt_rs, cur_la, nxt_la, cur_lb, nxt_lb;
  logic [N-1:0] pend, sticky;
  logic [W-1:0] opa [N];
  logic [W-1:0] opb [N];
  int glog [$];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic int arb(input logic [N-1:0] r, input int p);
    for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
    return -1;
  endfunction
  // Apply requester state to the pins and predict the next cycle from the current one.
  task automatic drive();
    logic [W:0] s;
    for (int i = 0; i < N; i++) begin
      req[i] = pend[i];
      a_in[i*W +: W] = opa[i];
      b_in[i*W +: W] = opb[i];
    end
    nxt_g = -1; nxt_v = 0; nxt_ptr = cur_ptr; nxt_rid = cur_rid; nxt_rs = cur_rs;
    nxt_rc = cur_rc; nxt_la = cur_la; nxt_lb = cur_lb;
    if (cur_g >= 0) begin
      s = {1'b0, cur_la} + {1'b0, cur_lb};
      nxt_v = 1; nxt_rid = cur_g; nxt_rc = s[W]; nxt_rs = s[W-1:0];
`ifdef ADDER_SHARE_ARB_SAT_EN
      if (s[W]) nxt_rs = '1;
`endif
      nxt_ptr = (cur_g + 1) % N;
    end else begin
      nxt_g = arb(req, cur_ptr);
      if (nxt_g >= 0) begin
        nxt_la = opa[nxt_g];
        nxt_lb = opb[nxt_g];
      end
    end
  endtask
  task automatic step();
    @(posedge clk);
    cur_g = nxt_g; cur_v = nxt_v; cur_ptr = nxt_ptr; cur_rid = nxt_rid;
    cur_rs = nxt_rs; cur_rc = nxt_rc; cur_la = nxt_la; cur_lb = nxt_lb;
    #1;
    chk("gnt", gnt, cur_g >= 0 ? 32'(1) << cur_g : 0);
    chk("busy", busy, cur_g >= 0 || cur_v);
    chk("rsp_valid", rsp_valid, cur_v);
    chk("rsp_id", rsp_id, cur_rid);
    chk("rsp_sum", rsp_sum, cur_rs);
    chk("rsp_carry", rsp_carry, cur_rc);
    chk("add_a", add_a, cur_g >= 0 ? cur_la : 0);
    chk("add_b", add_b, cur_g >= 0 ? cur_lb : 0);
    if (cur_g >= 0) glog.push_back(cur_g);
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        pend[i] = 0;
        if (rnd) begin opa[i] = W'($urandom); opb[i] = W'($urandom); end
      end else if (sticky[i]) pend[i] = 1;
      else if (rnd) begin
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1; opa[i] = W'($urandom); opb[i] = W'($urandom);
        end else if (pend[i] && $urandom_range(15) == 0) pend[i] = 0;
      end
    end
    drive();
  endtask
  task automatic run(input int n);
    repeat (n) step();
  endtask
  task automatic do_reset();
    rst = 1;
    #3;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_sum", rsp_sum, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    cur_g = -1; cur_v = 0; cur_ptr = 0; cur_rid = 0; cur_rs = 0; cur_rc = 0; cur_la = 0; cur_lb = 0;
    pend = '0; sticky = '0;
    glog.delete();
    @(negedge clk);
    rst = 0;
    drive();
  endtask
  task automatic check_log(input string tag, input int e [$]);
    chk({tag, "_count"}, glog.size(), e.size());
    for (int i = 0; i < e.size() && i < glog.size(); i++) chk(tag, glog[i], e[i]);
  endtask
  initial begin
    ncmp = 0; nbad = 0; rnd = 0; pend = '0; sticky = '0;
    for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
    do_reset();
    pend[0] = 1; opa[0] = 4'h3; opb[0] = 4'hA; drive();
    run(4);
    check_log("single_order", '{0});
    chk("single_sum", rsp_sum, 4'hD);
    chk("single_carry", rsp_carry, 0);
    chk("single_id", rsp_id, 0);
    do_reset();
    for (int i = 0; i < N; i++) begin pend[i] = 1; opa[i] = W'($urandom); opb[i] = W'($urandom); end
    drive();
    run(9);
    check_log("all4_order", '{0, 1, 2, 3});
    do_reset();
    sticky = 4'b1010; pend = 4'b1010; drive();
    run(10);
    check_log("fair_order", '{1, 3, 1, 3, 1});
    sticky = '0; pend = '0; drive();
    run(2);
    pend[2] = 1; opa[2] = 4'h5; opb[2] = 4'hB; drive();
    run(3);
`ifdef ADDER_SHARE_ARB_SAT_EN
    chk("ovf_sum", rsp_sum, 4'hF);
`else
    chk("ovf_sum", rsp_sum, 4'h0);
`endif
    chk("ovf_carry", rsp_carry, 1);
    pend[1] = 1; opa[1] = 4'h7; opb[1] = 4'h4; drive();
    run(1);
    opa[1] = 4'hF; drive();
    run(1);
    chk("opchg_sum", rsp_sum, 4'hB);
    run(1);
    pend[2] = 1; opa[2] = 4'h1; opb[2] = 4'h2; drive();
    run(3);
    pend[2] = 1; drive();
    run(1);
    chk("pre_rst_gnt", gnt, 4'b0100);
    do_reset();
    pend = 4'b1010; drive();
    run(5);
    pend = 4'b1000; drive();
    run(3);
    check_log("post_rst_order", '{1, 3, 3});
    do_reset();
    rnd = 1;
    run(400);
    rnd = 0; pend = '0; drive();
    run(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule
